// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle divide sequencer.
//   div_state_t    : sequencer states (IDLE, BUSY, DONE)
//   DIV_W          : default operand width
//   DIV_CNT_W      : iteration counter width
//   DIV_BY_ZERO_LO : quotient returned for a zero divisor (all ones)
package div_pkg;

  localparam int DIV_W = 32;
  localparam int DIV_CNT_W = 6;
  localparam logic [DIV_W-1:0] DIV_BY_ZERO_LO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: execute-stage <-> divide sequencer signals.
//   master : pipeline side (drives start/signed_div/a/b/annul, sees results)
//   slave  : div_ctrl side
// Handshake: the pipeline raises start with operands in E and holds it
// (stalled by div_stall) until result_valid; result_valid is a one-cycle
// pulse during which lo/hi are valid. annul cancels whatever is in flight
// and overrides every other input in that cycle.
interface div_ctrl_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) ();

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             div_stall;
  logic             result_valid;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, signed_div, a, b, annul,
    input  div_stall, result_valid, lo, hi
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output div_stall, result_valid, lo, hi
  );

endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate. Used both to take the
// magnitude of an operand (negate = operand is negative) and to apply the
// final sign to quotient/remainder.
//   value  : input word
//   negate : 1 = return -value (mod 2^WIDTH), 0 = pass through
//   result : output word
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: radix-2 restoring divide sequencer for DIV/DIVU in the execute
// stage. Stalls the pipeline while iterating, then pulses result_valid for
// one cycle with quotient on lo and remainder on hi.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_ctrl_if slave (start/signed_div/a/b/annul in,
//                div_stall/result_valid/lo/hi out)
//   dbgState   : current sequencer state, for observation only
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  div_ctrl_if.slave    bus,
  output div_state_t   dbgState
);

  div_state_t           state, stateNext;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     divisorMag;
  logic                 quoNeg, remNeg;
  logic [WIDTH-1:0]     loQ, hiQ;

  logic [WIDTH-1:0]     absA, absB;
  logic                 negA, negB;
  logic [WIDTH:0]       shifted, trial, remNext;
  logic [WIDTH-1:0]     quoNext, fixedLo, fixedHi;
  logic                 fits, lastIter;

  assign negA = bus.signed_div & bus.a[WIDTH-1];
  assign negB = bus.signed_div & bus.b[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) uAbsA (.value(bus.a), .negate(negA), .result(absA));
  div_sign_fix #(.WIDTH(WIDTH)) uAbsB (.value(bus.b), .negate(negB), .result(absB));

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor in
  // WIDTH+1 bits; the MSB of the difference is the borrow.
  assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisorMag};
  assign fits     = ~trial[WIDTH];
  assign remNext  = fits ? trial : shifted;
  assign quoNext  = {quo[WIDTH-2:0], fits};
  assign lastIter = (cnt == DIV_CNT_W'(WIDTH-1));

  // Sign fix-up is applied to the values produced by the final iteration so
  // lo/hi are registered on the same edge that enters DONE.
  div_sign_fix #(.WIDTH(WIDTH)) uFixLo (.value(quoNext), .negate(quoNeg), .result(fixedLo));
  div_sign_fix #(.WIDTH(WIDTH)) uFixHi (.value(remNext[WIDTH-1:0]), .negate(remNeg), .result(fixedHi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (bus.start) stateNext = (bus.b == '0) ? DONE : BUSY;
      BUSY: if (lastIter) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.annul) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      divisorMag <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      loQ        <= '0;
      hiQ        <= '0;
    end else if (!bus.annul) begin
      if (state == IDLE && bus.start) begin
        divisorMag <= absB;
        quoNeg     <= negA ^ negB;
        remNeg     <= negA;
        if (bus.b == '0) begin
          // Zero divisor: fixed quotient, raw (unsigned-looking) dividend.
          loQ <= WIDTH'(DIV_BY_ZERO_LO);
          hiQ <= bus.a;
        end else begin
          rem <= '0;
          quo <= absA;
          cnt <= '0;
        end
      end else if (state == BUSY) begin
        rem <= remNext;
        quo <= quoNext;
        cnt <= cnt + DIV_CNT_W'(1);
        if (lastIter) begin
          loQ <= fixedLo;
          hiQ <= fixedHi;
        end
      end
    end
  end

  // rst_n gates the stall so a held start cannot stall the pipe in reset.
  assign bus.div_stall    = rst_n & ~bus.annul &
                            (((state == IDLE) & bus.start) | (state == BUSY));
  assign bus.result_valid = (state == DONE) & ~bus.annul;
  assign bus.lo           = loQ;
  assign bus.hi           = hiQ;
  assign dbgState         = state;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the 5-stage MIPS pipeline's execute stage. It accepts a DIV/DIVU issued in E and runs a radix-2 restoring division over WIDTH iterations. It holds the pipeline by driving the hazard unit's `div_stallE`, then presents quotient (LO) and remainder (HI) for one cycle so the HI/LO write path captures them as the instruction leaves E. It also handles signed fix-up, divide-by-zero and cancellation by pipeline flush.

## Interface
- `WIDTH`, 32: operand width; iteration count equals WIDTH.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: DIV/DIVU valid in E; held high by the stalled pipeline until `result_valid`.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU; sampled with `start` in IDLE.
- `a` in WIDTH: dividend (rs); sampled in IDLE.
- `b` in WIDTH: divisor (rt); sampled in IDLE.
- `annul` in 1: flush/exception cancel; overrides every other input.
- `div_stall` out 1: combinational; feeds `div_stallE`.
- `result_valid` out 1: registered; high for exactly one cycle (DONE).
- `lo` out WIDTH: quotient; valid when `result_valid`.
- `hi` out WIDTH: remainder; valid when `result_valid`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `start`=1, `annul`=0:
  - latch `|a|`, `|b|`, quotient sign (`a[W-1]^b[W-1]` if signed) and remainder sign (`a[W-1]` if signed).
  - if `b`==0, go to DONE with `lo`=all ones and `hi`=`a` (raw).
  - otherwise clear the partial remainder (WIDTH+1 bits), load the dividend magnitude into the quotient shift register, set the counter to 0 and go to BUSY.
- BUSY, each cycle:
  - shift {rem,quo} left 1.
  - trial-subtract the divisor. If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
  - increment the 6-bit counter.
  - after iteration WIDTH-1, go to DONE.
- Entering DONE from BUSY, register `lo`/`hi`:
  - `lo` = quotient, negated if quotient sign is 1.
  - `hi` = remainder, negated if remainder sign is 1.
- DONE: `result_valid`=1; next state is always IDLE (the pipeline advances this cycle). `start` high in the following IDLE cycle is a new instruction.
- `div_stall` = `(IDLE & start & ~annul) | (BUSY & ~annul)`. It is 0 in DONE.
- `annul`=1 in any state:
  - next state is IDLE.
  - `div_stall` is forced 0; `result_valid` is forced 0 in that cycle.
  - `hi`/`lo` keep their last values.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0, via magnitude arithmetic mod 2^WIDTH.
- Arithmetic: magnitudes are unsigned WIDTH bits (|0x80000000| = 0x80000000). The trial subtract is WIDTH+1 bits wide; its borrow is the MSB.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, counter 0.
  - `lo`=`hi`=0, `result_valid`=0.
  - `div_stall`=0 while `rst_n`=0, regardless of `start`.
- Normal divide: `div_stall` high for WIDTH+1 cycles (1 IDLE + 32 BUSY), `result_valid` on cycle 34 counted from the `start` cycle as 1.
- Divide-by-zero: 1 stall cycle; `result_valid` on cycle 2.
- Back-to-back divides: DONE → IDLE → new start; no idle gap is required beyond the DONE cycle.
- Reset mid-BUSY abandons the operation immediately; no `result_valid` follows.
- `a`, `b`, `signed_div` changes after the IDLE capture cycle are ignored.

## Structure
- Shared package `div_pkg`:
  - `div_state_t` enum (IDLE/BUSY/DONE).
  - `DIV_W`=32.
  - `DIV_CNT_W`=6.
  - `DIV_BY_ZERO_LO` constant (all ones).
- Sub-module `div_sign_fix`: combinational; does conditional two's-complement negate and abs. It is instantiated for operand abs (×2) and result fix-up (×2).
- The iteration datapath and FSM live in `div_ctrl`.

## Test plan
- **Unsigned divide:** DIVU 100/7 → `div_stall` high 33 cycles, then `result_valid` 1 cycle, `lo`=14, `hi`=2.
- **Signed divide:** DIV -7/2 (0xFFFFFFF9/2) → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Also DIV 7/-2 → `lo`=0xFFFFFFFD, `hi`=1.
- **Zero divisor and overflow edge:**
  - DIVU 0x12345678/0 → 1 stall cycle, `lo`=0xFFFFFFFF, `hi`=0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Cancel mid-operation:** `annul` pulsed at BUSY iteration 10 → `div_stall` drops that cycle, no `result_valid`. A following DIVU 9/3 completes normally with `lo`=3, `hi`=0.
- **Reset mid-operation:** `rst_n` low during BUSY → outputs 0 immediately. After release with `start`=0, `div_stall` stays 0.
- **Back-to-back divides:** `start` held through DONE, then DIVU 0xFFFFFFFF/1 → second op begins the cycle after DONE with `lo`=0xFFFFFFFF, `hi`=0. Total stall is 2×33 cycles plus 1 DONE cycle between.
